rect_plotter: RTL
=================

# rect_plotter

Rectangle plotting engine and the responder side of the game controller's draw/erase handshake. One instance sits behind each sprite enable (helicopter, obstacle A, B, C). The controller raises `enable` with `erase` and drives base coordinates. The block rasterises a WIDTH_PX × HEIGHT_PX rectangle into the VGA adapter's pixel-write port, one pixel per clock, then holds `done` until the controller releases `enable`.

## Interface
- WIDTH_PX, 8, rectangle width in pixels (≥1)
- HEIGHT_PX, 8, rectangle height in pixels (≥1)
- FG_COLOUR, 3'b111, colour used when drawing
- BG_COLOUR, 3'b000, colour used when erasing
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  level request from controller; held high until `done` seen
- erase  in  1  1 = paint BG_COLOUR, 0 = paint FG_COLOUR; sampled with `enable`
- base_x  in  8  left column of rectangle, screen 0..159
- base_y  in  7  top row of rectangle, screen 0..119
- done  out  1  request complete; combinational, high only in state DONE
- x  out  8  pixel column to VGA adapter, registered
- y  out  7  pixel row to VGA adapter, registered
- colour  out  3  pixel colour to VGA adapter, registered
- plot  out  1  pixel write strobe to VGA adapter, registered

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: if `enable`=1, latch base_x, base_y and erase, clear cx and cy, go to DRAW. Otherwise stay.
- DRAW, each cycle:
  - x ← bx+cx; y ← by+cy; colour ← erase ? BG_COLOUR : FG_COLOUR; plot ← 1.
  - Advance in raster order, cx fastest: cx wraps at WIDTH_PX−1 and cy increments.
  - At cx=WIDTH_PX−1 and cy=HEIGHT_PX−1, go to DONE.
- DONE: plot ← 0 and `done`=1. Stay while `enable`=1; go to IDLE when `enable`=0.
- Base coordinates and erase are latched. Changes during DRAW or DONE are ignored.
- Deasserting `enable` mid-DRAW does not abort the rectangle. It completes, then `done` is high for exactly one cycle before IDLE.
- Arithmetic:
  - x sum is 8-bit and y sum is 7-bit, computed with one extra carry bit.
  - Without the clip feature, the sum truncates (wraps modulo 256 / 128).
- Counters: cx is ⌈log2 WIDTH_PX⌉ bits and cy is ⌈log2 HEIGHT_PX⌉ bits, minimum 1.
- In IDLE and DONE, x, y and colour hold their last values and plot is 0.
- Reset in any state: state → IDLE; x, y, colour, plot ← 0; `done` = 0. Counters and latches clear.
- `enable` is high in reset's release cycle: a new request starts on the first non-reset edge.

## Timing
- N = WIDTH_PX·HEIGHT_PX.
- Edge E0: `enable` is sampled high in IDLE.
- Edges E1..EN: plot is registered high with pixels 0..N−1, so plot is high for N consecutive cycles.
- After EN: state is DONE and `done`=1. This overlaps the final plot cycle; the adapter samples the last pixel at E(N+1).
- Edge E(N+1): plot ← 0. The controller samples `done`, and `enable` falls after E(N+1).
- First edge with `enable`=0 in DONE: return to IDLE, and `done` falls.
- Latency: N+1 edges from request to `done`. Minimum gap between requests is one IDLE cycle.
- No pixel is written outside DRAW. No two requests overlap.

## Configuration
- RECT_PLOTTER_CLIP_EN defined:
  - During DRAW, a pixel with unclipped x sum ≥160 or y sum ≥120 registers plot ← 0.
  - x, y and colour still update for that pixel.
  - Clipped pixels still consume their cycle, so latency is unchanged.
- RECT_PLOTTER_CLIP_EN undefined: no clipping; coordinates wrap per the arithmetic rules.

## Test plan
- WIDTH_PX=HEIGHT_PX=2, base (10,20), erase=0, enable held until done:
  - plot high 4 cycles with (10,20), (11,20), (10,21), (11,21), colour 3'b111.
  - done high from the 4th plot cycle until enable falls; then IDLE.
- Same request with erase=1 → identical coordinate sequence with colour 3'b000.
- RECT_PLOTTER_CLIP_EN defined, 2×2 at (159,119):
  - Only (159,119) has plot=1; the other 3 cycles have plot=0.
  - done after 5 edges.
- Without the macro, the same request → plot=1 for (159,119), (160,119), (159,120), (160,120), with outputs wrapped to 8 and 7 bits.
- 8×8 request, enable dropped after 3 cycles and base_x changed mid-draw:
  - All 64 pixels are plotted at the original base.
  - done is high exactly one cycle, then IDLE.
- reset asserted at pixel 30 of an 8×8 draw:
  - Next cycle: plot=0, x=0, y=0, colour=0, done=0, IDLE.
  - A new request redraws from pixel 0.

Source files
------------

// File: rtl/rect_plotter.sv
// Rectangle rasteriser answering the controller's enable/done handshake; one pixel per clock.
// Optional build macro RECT_PLOTTER_CLIP_EN suppresses plot for pixels past the 160x120 screen.
module rect_plotter #(
  parameter int         WIDTH_PX  = 8,
  parameter int         HEIGHT_PX = 8,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       erase,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  // state | meaning
  // IDLE  | waiting for enable; latches base and erase on request
  // DRAW  | one pixel registered per cycle, raster order, cx fastest
  // DONE  | done high, plot low; waits for enable to fall

  localparam int CXW = (WIDTH_PX > 1) ? $clog2(WIDTH_PX) : 1;
  localparam int CYW = (HEIGHT_PX > 1) ? $clog2(HEIGHT_PX) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(WIDTH_PX - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(HEIGHT_PX - 1);

`ifdef RECT_PLOTTER_CLIP_EN
  localparam int XSW = 9;
  localparam int YSW = 8;
`else
  // Without clipping the carry bit would have no reader, so sums wrap at native width.
  localparam int XSW = 8;
  localparam int YSW = 7;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [7:0]     bx_q, bx_d;
  logic [6:0]     by_q, by_d;
  logic           erase_q, erase_d;
  logic [7:0]     x_q, x_d;
  logic [6:0]     y_q, y_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d;
  logic [XSW-1:0] sum_x;
  logic [YSW-1:0] sum_y;

  assign sum_x = XSW'(bx_q) + XSW'(cx_q);
  assign sum_y = YSW'(by_q) + YSW'(cy_q);

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    bx_d     = bx_q;
    by_d     = by_q;
    erase_d  = erase_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          bx_d    = base_x;
          by_d    = base_y;
          erase_d = erase;
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        x_d      = sum_x[7:0];
        y_d      = sum_y[6:0];
        colour_d = erase_q ? BG_COLOUR : FG_COLOUR;
        plot_d   = 1'b1;
`ifdef RECT_PLOTTER_CLIP_EN
        if ((sum_x >= 9'd160) || (sum_y >= 8'd120)) plot_d = 1'b0;
`endif
        if (cx_q == CX_LAST) begin
          cx_d = '0;
          if (cy_q == CY_LAST) begin
            cy_d    = '0;
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + CYW'(1);
          end
        end else begin
          cx_d = cx_q + CXW'(1);
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      erase_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      erase_q  <= erase_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign done   = (state_q == S_DONE);
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule
